// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push/pop, head reads 0 when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  fetch_entry_t               entry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t          mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO accepts a push only alongside a pop of the head.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: PC, RUN/HALT control and fetch buffer toward decode.
// Optional FETCH_BYPASS_EN presents the memory word directly when the buffer is empty.
module ifetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 128,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        fetch_halted
);

  logic [31:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;

  logic         fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  fetch_entry_t fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic         pc_in_range, bypass;
  logic         unused_sig;

  assign unused_sig   = ^{redirect_pc[1:0], fifo_count};
  assign imem_addr    = pc_q;
  assign pc_in_range  = (pc_q < 32'(IMEM_BYTES));
  assign fetch_halted = (state_q == HALT);

`ifdef FETCH_BYPASS_EN
  // Reset is gated in so the bypass path cannot raise id_valid while held in reset.
  assign bypass = fifo_empty && (state_q == RUN) && pc_in_range && !redirect_valid && !reset;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    if (bypass) begin
      id_valid = 1'b1;
      id_pc    = pc_q;
      id_instr = imem_rdata;
    end else begin
      id_valid = !fifo_empty;
      id_pc    = fifo_head.pc;
      id_instr = fifo_head.instr;
    end
  end

  assign fifo_pop = id_valid && id_ready && !bypass;

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = {redirect_pc[31:2], 2'b00};
      state_d    = RUN;
    end else if (state_q == RUN) begin
      if (!pc_in_range) begin
        state_d = HALT;
      end else if (bypass) begin
        if (id_ready) pc_d = pc_q + 32'(INSTR_BYTES);
      end else if (!fifo_full || fifo_pop) begin
        fifo_push = 1'b1;
        pc_d      = pc_q + 32'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .entry_i ({pc_q, imem_rdata}),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: streaming, stall, redirect, halt/drain and async reset.
module tb_ifetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        fetch_halted;

  logic [31:0] mem [32];
  int n_cmp;
  int n_fail;

  ifetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (128),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .fetch_halted   (fetch_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    imem_rdata = 32'h0;
    if (imem_addr < 32'd128) imem_rdata = mem[imem_addr[6:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    step();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    id_ready       = ready;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    step();
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", id_pc); end
    n_cmp++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", id_instr); end
    n_cmp++; if (fetch_halted !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b want 0", fetch_halted); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_instr !== mem[k]) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 k, id_valid, id_pc, id_instr, 32'(4 * k), mem[k]);
      end
      if (k == 1) begin
        n_cmp++;
        if (id_instr !== 32'h0050_0093) begin
          n_fail++; $display("FAIL stream_addi: got %h want 00500093", id_instr);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr: got %h want 8", imem_addr); end
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0", id_valid, id_pc);
    end
    step();
    n_cmp++; if (imem_addr !== 32'h8 || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL stall_hold: got addr=%h pc=%h want addr=8 pc=0", imem_addr, id_pc);
    end
    id_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_instr !== mem[k]) begin
        n_fail++;
        $display("FAIL drain[%0d]: got v=%b pc=%h ins=%h want pc=%h ins=%h",
                 k, id_valid, id_pc, id_instr, 32'(4 * k), mem[k]);
      end
    end
  endtask

  task automatic test_redirect();
    // Head 16 now, pc 24: stop decode so the FIFO holds two entries.
    id_ready = 1'b0;
    step();
    step();
    n_cmp++; if (id_pc !== 32'h10 || imem_addr !== 32'h18) begin
      n_fail++; $display("FAIL redir_full: got pc=%h addr=%h want pc=10 addr=18", id_pc, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h16;
    step();
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 32'h14) begin
      n_fail++; $display("FAIL redir_flush: got v=%b addr=%h want v=0 addr=14", id_valid, imem_addr);
    end
    redirect_valid = 1'b0; id_ready = 1'b1;
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h14 || id_instr !== mem[5]) begin
      n_fail++; $display("FAIL redir_first: got v=%b pc=%h ins=%h want pc=14 ins=%h",
                         id_valid, id_pc, id_instr, mem[5]);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 64 && imem_addr !== 32'd128; i++) step();
    n_cmp++; if (imem_addr !== 32'd128) begin
      n_fail++; $display("FAIL halt_timeout: got addr=%h want 80", imem_addr);
    end
    n_cmp++; if (id_pc !== 32'd124 || fetch_halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_pre: got pc=%h h=%b want pc=7c h=0", id_pc, fetch_halted);
    end
    id_ready = 1'b0;
    step();
    n_cmp++; if (fetch_halted !== 1'b1 || imem_addr !== 32'd128) begin
      n_fail++; $display("FAIL halt_enter: got h=%b addr=%h want h=1 addr=80", fetch_halted, imem_addr);
    end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'd124) begin
      n_fail++; $display("FAIL halt_nopush: got v=%b pc=%h want v=1 pc=7c", id_valid, id_pc);
    end
    id_ready = 1'b1;
    step();
    n_cmp++; if (id_valid !== 1'b0 || fetch_halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_drain: got v=%b h=%b want v=0 h=1", id_valid, fetch_halted);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    n_cmp++; if (fetch_halted !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_exit: got h=%b v=%b want h=0 v=0", fetch_halted, id_valid);
    end
    redirect_valid = 1'b0;
    step();
    n_cmp++; if (id_pc !== 32'h20 || id_instr !== mem[8]) begin
      n_fail++; $display("FAIL halt_resume: got pc=%h ins=%h want pc=20 ins=%h", id_pc, id_instr, mem[8]);
    end
    // Redirect out of range: RUN for one cycle, then HALT again.
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (fetch_halted !== 1'b0 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL oor_run: got h=%b addr=%h want h=0 addr=100", fetch_halted, imem_addr);
    end
    step();
    n_cmp++; if (fetch_halted !== 1'b1 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL oor_halt: got h=%b v=%b want h=1 v=0", fetch_halted, id_valid);
    end
  endtask

  task automatic test_async_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0; id_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    step();
    n_cmp++; if (id_valid !== 1'b1 || imem_addr !== 32'h8) begin
      n_fail++; $display("FAIL arst_pre: got v=%b addr=%h want v=1 addr=8", id_valid, imem_addr);
    end
    reset = 1'b1;
    #2;
    n_cmp++; if (id_valid !== 1'b0 || fetch_halted !== 1'b0 || imem_addr !== 32'h0 || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL arst_now: got v=%b h=%b addr=%h pc=%h want all 0",
                         id_valid, fetch_halted, imem_addr, id_pc);
    end
    step();
    reset = 1'b0; id_ready = 1'b1;
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL arst_restart: got v=%b pc=%h want v=1 pc=0", id_valid, id_pc);
    end
  endtask

  task automatic test_bypass();
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h0020_0113) begin
      n_fail++; $display("FAIL byp_first: got v=%b pc=%h ins=%h want v=1 pc=8 ins=00200113",
                         id_valid, id_pc, id_instr);
    end
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== mem[3]) begin
      n_fail++; $display("FAIL byp_next: got v=%b pc=%h ins=%h want pc=c ins=%h",
                         id_valid, id_pc, id_instr, mem[3]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0193 | (32'(i) << 20);
    mem[1] = 32'h0050_0093;
    mem[2] = 32'h0020_0113;
    test_reset();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`else
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
